// File: rtl/tetris_move_pkg.sv
// Shared types for the move sequencer: move kinds, FSM states and wall-kick order.
package tetris_move_pkg;

    // Move kinds; the numeric value doubles as the bit position in the pending vector
    typedef enum logic [2:0] {
        MV_LEFT  = 3'd0,
        MV_RIGHT = 3'd1,
        MV_ROT   = 3'd2,
        MV_DOWN  = 3'd3,
        MV_GRAV  = 3'd4,
        MV_DROP  = 3'd5
    } move_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_KICK  = 2'd2,
        ST_LOCK  = 2'd3
    } seq_state_t;

    // Kick attempts: first try shifting the rotated piece to x+1, then to x-1
    typedef logic [0:0] kick_idx_t;
    localparam kick_idx_t KICK_FIRST = 1'b0;
    localparam kick_idx_t KICK_LAST  = 1'b1;

    function automatic logic kick_moves_plus(input kick_idx_t idx);
        return idx == KICK_FIRST;
    endfunction

endpackage

// File: rtl/move_target_calc.sv
// Combinational candidate generator: applies one move (or kick attempt) to a base
// position and flags when that move would take the origin outside the legal area.
module move_target_calc
    import tetris_move_pkg::*;
#(
    parameter int X_W   = 4,
    parameter int Y_W   = 4,
    parameter int ROT_W = 2,
    parameter int X_MAX = 6,
    parameter int Y_MAX = 15
) (
    input  logic [X_W-1:0]   base_x,
    input  logic [Y_W-1:0]   base_y,
    input  logic [ROT_W-1:0] base_rot,
    input  move_kind_t       kind,
    input  logic             kick_active,
    input  kick_idx_t        kick_idx,
    output logic [X_W-1:0]   cand_x,
    output logic [Y_W-1:0]   cand_y,
    output logic [ROT_W-1:0] cand_rot,
    output logic             at_bound
);

    localparam logic [X_W-1:0] XMAX = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YMAX = Y_W'(Y_MAX);

    // Build the candidate; at_bound means the move must not be offered to the checker
    always_comb begin
        cand_x   = base_x;
        cand_y   = base_y;
        cand_rot = base_rot;
        at_bound = 1'b0;
        case (kind)
            MV_LEFT: begin
                cand_x   = base_x + X_W'(1);
                at_bound = (base_x >= XMAX);
            end
            MV_RIGHT: begin
                cand_x   = base_x - X_W'(1);
                at_bound = (base_x == '0);
            end
            MV_ROT: begin
                cand_rot = base_rot + ROT_W'(1);
                if (kick_active) begin
                    if (kick_moves_plus(kick_idx)) begin
                        cand_x   = base_x + X_W'(1);
                        at_bound = (base_x >= XMAX);
                    end else begin
                        cand_x   = base_x - X_W'(1);
                        at_bound = (base_x == '0);
                    end
                end
            end
            MV_DOWN, MV_GRAV, MV_DROP: begin
                cand_y   = base_y + Y_W'(1);
                at_bound = (base_y >= YMAX);
            end
            default: begin
                cand_x = base_x;
            end
        endcase
    end

endmodule

// File: rtl/move_sequencer.sv
// Owns the active piece position/rotation. Button and gravity pulses are latched as
// pending events, dispatched by priority, checked against the board through a
// valid/done handshake, then committed, kicked, discarded or turned into a lock.
module move_sequencer
    import tetris_move_pkg::*;
#(
    parameter int X_W     = 4,
    parameter int Y_W     = 4,
    parameter int ROT_W   = 2,
    parameter int X_MAX   = 6,
    parameter int Y_MAX   = 15,
    parameter bit KICK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_left_en,
    input  logic             btn_right_en,
    input  logic             btn_rotate_en,
    input  logic             btn_down_en,
    input  logic             btn_drop_en,
    input  logic             grav_tick,
    input  logic             spawn,
    input  logic [X_W-1:0]   spawn_x,
    input  logic [Y_W-1:0]   spawn_y,
    input  logic [ROT_W-1:0] spawn_rot,
    output logic [X_W-1:0]   cur_pos_x,
    output logic [Y_W-1:0]   cur_pos_y,
    output logic [ROT_W-1:0] cur_rot,
    output logic [X_W-1:0]   test_pos_x,
    output logic [Y_W-1:0]   test_pos_y,
    output logic [ROT_W-1:0] test_rot,
    output logic             check_valid,
    input  logic             check_done,
    input  logic             check_collide,
    output logic             lock_piece,
    output logic             busy
);

    seq_state_t       state;
    move_kind_t       act_kind;
    logic             kicking;
    kick_idx_t        kick_idx;
    logic             frozen;
    logic [5:0]       pending;

    logic [5:0]       ev_in;
    logic [5:0]       ev_all;
    logic             have_event;
    move_kind_t       win_kind;
    logic [5:0]       win_mask;

    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;
    logic [ROT_W-1:0] base_rot;
    move_kind_t       calc_kind;
    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;
    logic [ROT_W-1:0] cand_rot;
    logic             cand_bound;

    assign busy = (state != ST_IDLE);

    // Merge new pulses into the pending set and pick the highest-priority event
    always_comb begin
        ev_in      = frozen ? 6'b0 : {btn_drop_en, grav_tick, btn_down_en,
                                      btn_rotate_en, btn_right_en, btn_left_en};
        ev_all     = pending | ev_in;
        have_event = |ev_all;
        win_kind   = MV_LEFT;
        if (ev_all[MV_DROP])       win_kind = MV_DROP;
        else if (ev_all[MV_LEFT])  win_kind = MV_LEFT;
        else if (ev_all[MV_RIGHT]) win_kind = MV_RIGHT;
        else if (ev_all[MV_ROT])   win_kind = MV_ROT;
        else if (ev_all[MV_DOWN])  win_kind = MV_DOWN;
        else if (ev_all[MV_GRAV])  win_kind = MV_GRAV;
        win_mask = 6'b000001 << win_kind;
    end

    // While checking, the next drop step builds on the candidate about to be committed
    always_comb begin
        if (state == ST_CHECK) begin
            base_x   = test_pos_x;
            base_y   = test_pos_y;
            base_rot = test_rot;
        end else begin
            base_x   = cur_pos_x;
            base_y   = cur_pos_y;
            base_rot = cur_rot;
        end
        calc_kind = (state == ST_IDLE) ? win_kind : act_kind;
    end

    move_target_calc #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .ROT_W (ROT_W),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_calc (
        .base_x      (base_x),
        .base_y      (base_y),
        .base_rot    (base_rot),
        .kind        (calc_kind),
        .kick_active (state == ST_KICK),
        .kick_idx    (kick_idx),
        .cand_x      (cand_x),
        .cand_y      (cand_y),
        .cand_rot    (cand_rot),
        .at_bound    (cand_bound)
    );

    // Sequencer FSM with registered piece state, handshake and lock outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            act_kind    <= MV_LEFT;
            kicking     <= 1'b0;
            kick_idx    <= KICK_FIRST;
            frozen      <= 1'b0;
            pending     <= '0;
            cur_pos_x   <= '0;
            cur_pos_y   <= '0;
            cur_rot     <= '0;
            test_pos_x  <= '0;
            test_pos_y  <= '0;
            test_rot    <= '0;
            check_valid <= 1'b0;
            lock_piece  <= 1'b0;
        end else if (spawn) begin
            state       <= ST_IDLE;
            kicking     <= 1'b0;
            kick_idx    <= KICK_FIRST;
            frozen      <= 1'b0;
            pending     <= '0;
            cur_pos_x   <= spawn_x;
            cur_pos_y   <= spawn_y;
            cur_rot     <= spawn_rot;
            check_valid <= 1'b0;
            lock_piece  <= 1'b0;
        end else begin
            lock_piece <= 1'b0;
            pending    <= ev_all;
            case (state)
                ST_IDLE: begin
                    if (have_event) begin
                        pending  <= ev_all & ~win_mask;
                        act_kind <= win_kind;
                        kicking  <= 1'b0;
                        kick_idx <= KICK_FIRST;
                        if (cand_bound) begin
                            if (win_kind != MV_LEFT && win_kind != MV_RIGHT) begin
                                state      <= ST_LOCK;
                                lock_piece <= 1'b1;
                            end
                        end else begin
                            test_pos_x  <= cand_x;
                            test_pos_y  <= cand_y;
                            test_rot    <= cand_rot;
                            check_valid <= 1'b1;
                            state       <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (check_done) begin
                        if (!check_collide) begin
                            cur_pos_x <= test_pos_x;
                            cur_pos_y <= test_pos_y;
                            cur_rot   <= test_rot;
                            if (act_kind == MV_DROP) begin
                                if (cand_bound) begin
                                    check_valid <= 1'b0;
                                    state       <= ST_LOCK;
                                    lock_piece  <= 1'b1;
                                end else begin
                                    test_pos_y <= cand_y;
                                end
                            end else begin
                                check_valid <= 1'b0;
                                kicking     <= 1'b0;
                                state       <= ST_IDLE;
                            end
                        end else begin
                            check_valid <= 1'b0;
                            case (act_kind)
                                MV_DOWN, MV_GRAV, MV_DROP: begin
                                    state      <= ST_LOCK;
                                    lock_piece <= 1'b1;
                                end
                                MV_ROT: begin
                                    if (kicking) begin
                                        if (kick_idx == KICK_FIRST) begin
                                            kick_idx <= KICK_LAST;
                                            state    <= ST_KICK;
                                        end else begin
                                            kicking <= 1'b0;
                                            state   <= ST_IDLE;
                                        end
                                    end else if (KICK_EN) begin
                                        kicking  <= 1'b1;
                                        kick_idx <= KICK_FIRST;
                                        state    <= ST_KICK;
                                    end else begin
                                        state <= ST_IDLE;
                                    end
                                end
                                default: begin
                                    state <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                end
                ST_KICK: begin
                    if (cand_bound) begin
                        if (kick_idx == KICK_FIRST) begin
                            kick_idx <= KICK_LAST;
                        end else begin
                            kicking <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        test_pos_x  <= cand_x;
                        test_pos_y  <= cand_y;
                        test_rot    <= cand_rot;
                        check_valid <= 1'b1;
                        state       <= ST_CHECK;
                    end
                end
                ST_LOCK: begin
                    pending <= '0;
                    frozen  <= 1'b1;
                    kicking <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: a table of single-event scenarios plus
// hand-written sequences for latency, drop, priority, spawn abort and reset.
module tb_move_sequencer;
    import tetris_move_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_left_en, btn_right_en, btn_rotate_en, btn_down_en, btn_drop_en;
    logic       grav_tick, spawn;
    logic [3:0] spawn_x, spawn_y;
    logic [1:0] spawn_rot;
    logic [3:0] cur_pos_x, cur_pos_y, test_pos_x, test_pos_y;
    logic [1:0] cur_rot, test_rot;
    logic       check_valid, check_done, check_collide, lock_piece, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] sx;
        logic [3:0] sy;
        logic [1:0] sr;
        move_kind_t kind;
        logic [3:0] mask;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [1:0] er;
        int         nchk;
        int         nlock;
    } vec_t;

    vec_t vecs[16];

    move_sequencer #(
        .X_W(4), .Y_W(4), .ROT_W(2), .X_MAX(6), .Y_MAX(15), .KICK_EN(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_left_en   (btn_left_en),
        .btn_right_en  (btn_right_en),
        .btn_rotate_en (btn_rotate_en),
        .btn_down_en   (btn_down_en),
        .btn_drop_en   (btn_drop_en),
        .grav_tick     (grav_tick),
        .spawn         (spawn),
        .spawn_x       (spawn_x),
        .spawn_y       (spawn_y),
        .spawn_rot     (spawn_rot),
        .cur_pos_x     (cur_pos_x),
        .cur_pos_y     (cur_pos_y),
        .cur_rot       (cur_rot),
        .test_pos_x    (test_pos_x),
        .test_pos_y    (test_pos_y),
        .test_rot      (test_rot),
        .check_valid   (check_valid),
        .check_done    (check_done),
        .check_collide (check_collide),
        .lock_piece    (lock_piece),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] pos(input logic [3:0] x, input logic [3:0] y, input logic [1:0] r);
        return {22'b0, x, y, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setEvent(input move_kind_t k, input logic v);
        case (k)
            MV_LEFT:  btn_left_en   = v;
            MV_RIGHT: btn_right_en  = v;
            MV_ROT:   btn_rotate_en = v;
            MV_DOWN:  btn_down_en   = v;
            MV_GRAV:  grav_tick     = v;
            MV_DROP:  btn_drop_en   = v;
            default:  btn_left_en   = v;
        endcase
    endtask

    task automatic doSpawn(input logic [3:0] x, input logic [3:0] y, input logic [1:0] r);
        spawn = 1'b1; spawn_x = x; spawn_y = y; spawn_rot = r;
        tick();
        spawn = 1'b0;
    endtask

    // Answers each presented check with the next bit of mask until the sequencer idles
    task automatic runResponder(input logic [3:0] mask, output int nchk, output int nlock, output logic finished);
        nchk = 0; nlock = 0; finished = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (lock_piece) nlock++;
            if (!busy && !check_valid) begin
                finished = 1'b1;
                break;
            end
            if (check_valid) begin
                check_done    = 1'b1;
                check_collide = ((mask >> nchk) & 4'b0001) != 4'b0000;
                nchk++;
            end else begin
                check_done    = 1'b0;
                check_collide = 1'b0;
            end
            tick();
        end
        check_done = 1'b0; check_collide = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int   nchk, nlock;
        logic finished;
        doSpawn(v.sx, v.sy, v.sr);
        setEvent(v.kind, 1'b1);
        tick();
        setEvent(v.kind, 1'b0);
        runResponder(v.mask, nchk, nlock, finished);
        checkOutput({v.name, "_idle"}, 32'(finished), 32'd1);
        checkOutput({v.name, "_cur"}, pos(cur_pos_x, cur_pos_y, cur_rot), pos(v.ex, v.ey, v.er));
        checkOutput({v.name, "_checks"}, nchk, v.nchk);
        checkOutput({v.name, "_locks"}, nlock, v.nlock);
    endtask

    initial begin
        int   nchk, nlock, seen;
        logic finished;

        rst_n = 1'b0;
        btn_left_en = 0; btn_right_en = 0; btn_rotate_en = 0; btn_down_en = 0; btn_drop_en = 0;
        grav_tick = 0; spawn = 0; spawn_x = 0; spawn_y = 0; spawn_rot = 0;
        check_done = 0; check_collide = 0;

        vecs[0]  = '{"left_ok",        4'd3, 4'd0,  2'd0, MV_LEFT,  4'b0000, 4'd4, 4'd0,  2'd0, 1, 0};
        vecs[1]  = '{"left_at_max",    4'd6, 4'd5,  2'd0, MV_LEFT,  4'b0000, 4'd6, 4'd5,  2'd0, 0, 0};
        vecs[2]  = '{"right_at_zero",  4'd0, 4'd5,  2'd0, MV_RIGHT, 4'b0000, 4'd0, 4'd5,  2'd0, 0, 0};
        vecs[3]  = '{"right_ok",       4'd3, 4'd5,  2'd1, MV_RIGHT, 4'b0000, 4'd2, 4'd5,  2'd1, 1, 0};
        vecs[4]  = '{"rot_kick_skip",  4'd6, 4'd5,  2'd3, MV_ROT,   4'b0001, 4'd5, 4'd5,  2'd0, 2, 0};
        vecs[5]  = '{"rot_kick_minus", 4'd3, 4'd5,  2'd0, MV_ROT,   4'b0011, 4'd2, 4'd5,  2'd1, 3, 0};
        vecs[6]  = '{"rot_kick_fail",  4'd3, 4'd5,  2'd0, MV_ROT,   4'b0111, 4'd3, 4'd5,  2'd0, 3, 0};
        vecs[7]  = '{"rot_kick_plus",  4'd0, 4'd5,  2'd2, MV_ROT,   4'b0001, 4'd1, 4'd5,  2'd3, 2, 0};
        vecs[8]  = '{"rot_kick_edge",  4'd0, 4'd5,  2'd2, MV_ROT,   4'b0011, 4'd0, 4'd5,  2'd2, 2, 0};
        vecs[9]  = '{"down_ok",        4'd3, 4'd7,  2'd0, MV_DOWN,  4'b0000, 4'd3, 4'd8,  2'd0, 1, 0};
        vecs[10] = '{"grav_collide",   4'd3, 4'd7,  2'd0, MV_GRAV,  4'b0001, 4'd3, 4'd7,  2'd0, 1, 1};
        vecs[11] = '{"down_at_floor",  4'd3, 4'd15, 2'd0, MV_DOWN,  4'b0000, 4'd3, 4'd15, 2'd0, 0, 1};
        vecs[12] = '{"drop_collide",   4'd2, 4'd12, 2'd0, MV_DROP,  4'b0100, 4'd2, 4'd14, 2'd0, 3, 1};
        vecs[13] = '{"drop_floor",     4'd2, 4'd12, 2'd0, MV_DROP,  4'b0000, 4'd2, 4'd15, 2'd0, 3, 1};
        vecs[14] = '{"left_collide",   4'd3, 4'd5,  2'd0, MV_LEFT,  4'b0001, 4'd3, 4'd5,  2'd0, 1, 0};
        vecs[15] = '{"rot_wrap",       4'd4, 4'd5,  2'd3, MV_ROT,   4'b0000, 4'd4, 4'd5,  2'd0, 1, 0};

        // Reset state
        tick(); tick();
        checkOutput("reset_cur", pos(cur_pos_x, cur_pos_y, cur_rot), 32'd0);
        checkOutput("reset_test", pos(test_pos_x, test_pos_y, test_rot), 32'd0);
        checkOutput("reset_flags", {29'b0, check_valid, lock_piece, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency: event in N, candidate in N+1, commit visible in N+2
        doSpawn(4'd3, 4'd0, 2'd0);
        checkOutput("spawn_cur", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd3, 4'd0, 2'd0));
        btn_left_en = 1'b1;
        tick();
        btn_left_en = 1'b0;
        checkOutput("lat_valid", 32'(check_valid), 32'd1);
        checkOutput("lat_test", pos(test_pos_x, test_pos_y, test_rot), pos(4'd4, 4'd0, 2'd0));
        checkOutput("lat_cur_hold", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd3, 4'd0, 2'd0));
        check_done = 1'b1;
        tick();
        check_done = 1'b0;
        checkOutput("lat_commit", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd4, 4'd0, 2'd0));
        checkOutput("lat_release", {30'b0, check_valid, busy}, 32'd0);

        // Table of single-event scenarios
        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        // Drop with a left pulse mid-drop; then the piece stays frozen
        doSpawn(4'd2, 4'd12, 2'd0);
        btn_drop_en = 1'b1;
        tick();
        btn_drop_en = 1'b0;
        checkOutput("drop_first_test", pos(test_pos_x, test_pos_y, test_rot), pos(4'd2, 4'd13, 2'd0));
        check_done = 1'b1; check_collide = 1'b0; btn_left_en = 1'b1;
        tick();
        btn_left_en = 1'b0;
        runResponder(4'b0010, nchk, nlock, finished);
        checkOutput("drop_left_idle", 32'(finished), 32'd1);
        checkOutput("drop_left_cur", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd2, 4'd14, 2'd0));
        checkOutput("drop_left_lock", nlock, 1);
        btn_right_en = 1'b1;
        tick();
        btn_right_en = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (check_valid || busy) seen++;
            tick();
        end
        checkOutput("frozen_ignored", seen, 0);
        checkOutput("frozen_cur", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd2, 4'd14, 2'd0));

        // Left and rotate together: left first, rotate afterwards
        doSpawn(4'd3, 4'd5, 2'd0);
        btn_left_en = 1'b1; btn_rotate_en = 1'b1;
        tick();
        btn_left_en = 1'b0; btn_rotate_en = 1'b0;
        checkOutput("prio_first_test", pos(test_pos_x, test_pos_y, test_rot), pos(4'd4, 4'd5, 2'd0));
        check_done = 1'b1;
        tick();
        check_done = 1'b0;
        checkOutput("prio_first_cur", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd4, 4'd5, 2'd0));
        tick();
        checkOutput("prio_second_valid", 32'(check_valid), 32'd1);
        checkOutput("prio_second_test", pos(test_pos_x, test_pos_y, test_rot), pos(4'd4, 4'd5, 2'd1));
        check_done = 1'b1;
        tick();
        check_done = 1'b0;
        checkOutput("prio_second_cur", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd4, 4'd5, 2'd1));

        // Spawn aborts an in-flight check; a late done is ignored
        doSpawn(4'd3, 4'd5, 2'd0);
        btn_left_en = 1'b1;
        tick();
        btn_left_en = 1'b0;
        checkOutput("abort_valid_before", 32'(check_valid), 32'd1);
        doSpawn(4'd1, 4'd2, 2'd3);
        checkOutput("abort_valid_after", 32'(check_valid), 32'd0);
        checkOutput("abort_cur", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd1, 4'd2, 2'd3));
        check_done = 1'b1;
        tick();
        check_done = 1'b0;
        checkOutput("abort_late_done", pos(cur_pos_x, cur_pos_y, cur_rot), pos(4'd1, 4'd2, 2'd3));
        checkOutput("abort_idle", {30'b0, check_valid, busy}, 32'd0);

        // Reset dominates spawn
        rst_n = 1'b0; spawn = 1'b1; spawn_x = 4'd5; spawn_y = 4'd5; spawn_rot = 2'd1;
        tick();
        spawn = 1'b0;
        checkOutput("rst_spawn_cur", pos(cur_pos_x, cur_pos_y, cur_rot), 32'd0);
        checkOutput("rst_spawn_test", pos(test_pos_x, test_pos_y, test_rot), 32'd0);
        checkOutput("rst_spawn_flags", {29'b0, check_valid, lock_piece, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
